// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit scheduler.
package uart_pkg;

  typedef enum logic [1:0] {
    SCH_IDLE   = 2'd0,
    SCH_LAUNCH = 2'd1,
    SCH_ACTIVE = 2'd2,
    SCH_DRAIN  = 2'd3
  } sch_state_t;

  localparam int SCH_TIMEOUT_DEFAULT = 1023;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: nearest valid requester after last_grant, wrapping.
module uart_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  last_grant,
  output logic            any,
  output logic [IDW-1:0]  pick_id
);

  int             idx;
  logic [IDW-1:0] idx_sel;

  assign any = |req_valid;

  // Scan from farthest to nearest so the nearest valid requester wins.
  always_comb begin
    pick_id = '0;
    idx     = 0;
    idx_sel = '0;
    for (int off = NREQ; off >= 1; off--) begin
      idx     = (int'(last_grant) + off) % NREQ;
      idx_sel = IDW'(idx);
      if (req_valid[idx_sel]) begin
        pick_id = idx_sel;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NREQ byte requesters.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = SCH_TIMEOUT_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*WIDTH-1:0]    req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     tx_en,
  output logic [WIDTH-1:0]         tx_data,
  input  logic                     tx_busy,
  input  logic                     tx_done,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     sent_vld,
  output logic [$clog2(NREQ)-1:0]  sent_id,
  output logic                     err_timeout
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(TIMEOUT + 1);

  sch_state_t     state_reg;
  logic [CW-1:0]  cnt_reg;
  logic [IDW-1:0] last_grant_reg;

  logic             any;
  logic [IDW-1:0]   pick_id;
  logic [WIDTH-1:0] req_slice [NREQ];
  logic [NREQ-1:0]  pick_onehot;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign req_slice[gi]   = req_data[gi*WIDTH +: WIDTH];
      assign pick_onehot[gi] = (pick_id == IDW'(gi));
    end
  endgenerate

  uart_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req_valid  (req_valid),
    .last_grant (last_grant_reg),
    .any        (any),
    .pick_id    (pick_id)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= SCH_IDLE;
      cnt_reg        <= '0;
      last_grant_reg <= IDW'(NREQ - 1);  // requester 0 is first in line
      tx_en          <= 1'b0;
      tx_data        <= '0;
      req_ready      <= '0;
      grant_id       <= '0;
      sent_vld       <= 1'b0;
      sent_id        <= '0;
      err_timeout    <= 1'b0;
    end else begin
      req_ready   <= '0;
      sent_vld    <= 1'b0;
      err_timeout <= 1'b0;
      case (state_reg)
        SCH_IDLE: begin
          if (any) begin
            tx_data   <= req_slice[pick_id];
            grant_id  <= pick_id;
            req_ready <= pick_onehot;
            tx_en     <= 1'b1;
            cnt_reg   <= '0;
            state_reg <= SCH_LAUNCH;
          end
        end
        SCH_LAUNCH: begin
          if (tx_busy) begin
            tx_en     <= 1'b0;
            state_reg <= SCH_ACTIVE;
          end else if (cnt_reg == CW'(TIMEOUT)) begin
            // Transmitter never started: drop the byte but still move the pointer on.
            tx_en          <= 1'b0;
            err_timeout    <= 1'b1;
            last_grant_reg <= grant_id;
            state_reg      <= SCH_IDLE;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        SCH_ACTIVE: begin
          if (tx_done) begin
            state_reg <= SCH_DRAIN;
          end
        end
        SCH_DRAIN: begin
          // Wait for the done level to clear so it cannot satisfy the next grant.
          if (!tx_done && !tx_busy) begin
            sent_vld       <= 1'b1;
            sent_id        <= grant_id;
            last_grant_reg <= grant_id;
            state_reg      <= SCH_IDLE;
          end
        end
        default: state_reg <= SCH_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a cycle-stepped transmitter model.
module tb_uart_tx_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        tx_done;
  logic [1:0]  grant_id;
  logic        sent_vld;
  logic [1:0]  sent_id;
  logic        err_timeout;

  int vecs = 0;
  int errs = 0;
  int rdy_cnt = 0;

  logic [7:0] bytes [4] = '{8'h11, 8'hA5, 8'h33, 8'h44};

  uart_tx_sched #(
    .NREQ    (4),
    .WIDTH   (8),
    .TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_en       (tx_en),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .grant_id    (grant_id),
    .sent_vld    (sent_vld),
    .sent_id     (sent_id),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts cycles in which any req_ready is high.
  always @(negedge clk) if (req_ready != 4'b0) rdy_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    tx_busy = 1'b0;
    tx_done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] pack_bytes();
    return {bytes[3], bytes[2], bytes[1], bytes[0]};
  endfunction

  // One complete frame: grant, launch, busy, done hold, drain.
  task automatic do_frame(input int exp_id, input logic [7:0] exp_data, input int busy_dly,
                          input int done_len, input bit drop_mid);
    int n;
    int r0;
    bit early;
    logic [3:0] exp_rdy;
    exp_rdy = 4'(1 << exp_id);
    r0 = rdy_cnt;
    n = 0;
    do begin
      tick();
      n++;
    end while (req_ready === 4'b0 && n < 40);
    vecs++;
    if (n != 1) begin
      errs++;
      $display("FAIL grant_latency id=%0d got %0d cycles want 1", exp_id, n);
    end
    vecs++;
    if (req_ready !== exp_rdy) begin
      errs++;
      $display("FAIL req_ready got %b want %b", req_ready, exp_rdy);
    end
    vecs++;
    if (tx_en !== 1'b1 || tx_data !== exp_data || grant_id !== 2'(exp_id)) begin
      errs++;
      $display("FAIL launch tx_en=%b tx_data=%h grant_id=%0d want 1 %h %0d",
               tx_en, tx_data, grant_id, exp_data, exp_id);
    end
    for (int i = 0; i < busy_dly; i++) begin
      tick();
      if (i == 0 && drop_mid) begin
        req_valid = 4'b0;
        req_data = 32'hDEADBEEF;
      end
      vecs++;
      if (tx_en !== 1'b1 || req_ready !== 4'b0) begin
        errs++;
        $display("FAIL launch_hold tx_en=%b req_ready=%b want 1 0000", tx_en, req_ready);
      end
    end
    tx_busy = 1'b1;
    tick();
    vecs++;
    if (tx_en !== 1'b0) begin
      errs++;
      $display("FAIL tx_en_fall got %b want 0", tx_en);
    end
    repeat (4) tick();
    tx_busy = 1'b0;
    tx_done = 1'b1;
    early = 1'b0;
    for (int i = 0; i < done_len; i++) begin
      tick();
      if (sent_vld !== 1'b0 || req_ready !== 4'b0) early = 1'b1;
    end
    vecs++;
    if (early) begin
      errs++;
      $display("FAIL done_hold sent_vld or req_ready during done, want 0");
    end
    tx_done = 1'b0;
    tick();
    vecs++;
    if (sent_vld !== 1'b1 || sent_id !== 2'(exp_id)) begin
      errs++;
      $display("FAIL sent sent_vld=%b sent_id=%0d want 1 %0d", sent_vld, sent_id, exp_id);
    end
    vecs++;
    if (tx_data !== exp_data) begin
      errs++;
      $display("FAIL tx_data_stable got %h want %h", tx_data, exp_data);
    end
    vecs++;
    if (rdy_cnt - r0 != 1) begin
      errs++;
      $display("FAIL ready_pulses got %0d want 1", rdy_cnt - r0);
    end
  endtask

  task automatic test_reset();
    do_reset();
    vecs++;
    if (tx_en !== 1'b0 || tx_data !== 8'h00 || req_ready !== 4'b0 || grant_id !== 2'd0 ||
        sent_vld !== 1'b0 || sent_id !== 2'd0 || err_timeout !== 1'b0) begin
      errs++;
      $display("FAIL reset_values en=%b data=%h rdy=%b gid=%0d sv=%b sid=%0d err=%b want all 0",
               tx_en, tx_data, req_ready, grant_id, sent_vld, sent_id, err_timeout);
    end
  endtask

  task automatic test_single();
    do_reset();
    req_data = pack_bytes();
    req_valid = 4'b0010;
    do_frame(1, 8'hA5, 3, 1, 1'b1);
  endtask

  task automatic test_back_to_back();
    do_reset();
    req_data = pack_bytes();
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      do_frame(i % 4, bytes[i % 4], 2, 1, 1'b0);
    end
  endtask

  task automatic test_done_hold();
    do_reset();
    req_data = pack_bytes();
    req_valid = 4'b1111;
    do_frame(0, bytes[0], 2, 5, 1'b0);
    do_frame(1, bytes[1], 2, 1, 1'b0);
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    req_data = pack_bytes();
    req_valid = 4'b0001;
    tick();
    vecs++;
    if (req_ready !== 4'b0001 || tx_en !== 1'b1) begin
      errs++;
      $display("FAIL to_launch req_ready=%b tx_en=%b want 0001 1", req_ready, tx_en);
    end
    n = 0;
    do begin
      tick();
      n++;
    end while (err_timeout !== 1'b1 && n < 40);
    vecs++;
    if (n != 17) begin
      errs++;
      $display("FAIL timeout_latency got %0d cycles want 17", n);
    end
    vecs++;
    if (tx_en !== 1'b0) begin
      errs++;
      $display("FAIL timeout_tx_en got %b want 0", tx_en);
    end
    req_valid = 4'b0011;
    tick();
    vecs++;
    if (err_timeout !== 1'b0 || req_ready !== 4'b0010 || grant_id !== 2'd1) begin
      errs++;
      $display("FAIL timeout_next err=%b req_ready=%b gid=%0d want 0 0010 1",
               err_timeout, req_ready, grant_id);
    end
  endtask

  task automatic test_reset_active();
    do_reset();
    req_data = pack_bytes();
    req_valid = 4'b0100;
    tick();
    vecs++;
    if (req_ready !== 4'b0100 || tx_data !== bytes[2]) begin
      errs++;
      $display("FAIL ra_grant req_ready=%b tx_data=%h want 0100 %h", req_ready, tx_data, bytes[2]);
    end
    tx_busy = 1'b1;
    tick();
    tick();
    req_valid = 4'b1111;
    rst = 1'b1;
    tick();
    vecs++;
    if (tx_en !== 1'b0 || tx_data !== 8'h00 || req_ready !== 4'b0 || grant_id !== 2'd0 ||
        sent_vld !== 1'b0 || sent_id !== 2'd0 || err_timeout !== 1'b0) begin
      errs++;
      $display("FAIL ra_reset en=%b data=%h rdy=%b gid=%0d sv=%b sid=%0d err=%b want all 0",
               tx_en, tx_data, req_ready, grant_id, sent_vld, sent_id, err_timeout);
    end
    rst = 1'b0;
    tx_busy = 1'b0;
    tick();
    vecs++;
    if (req_ready !== 4'b0001 || grant_id !== 2'd0 || tx_data !== bytes[0]) begin
      errs++;
      $display("FAIL ra_first req_ready=%b gid=%0d tx_data=%h want 0001 0 %h",
               req_ready, grant_id, tx_data, bytes[0]);
    end
  endtask

  task automatic test_drop_mid();
    do_reset();
    req_data = pack_bytes();
    req_valid = 4'b1000;
    do_frame(3, bytes[3], 4, 2, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    tx_busy = 1'b0;
    tx_done = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_done_hold();
    test_timeout();
    test_reset_active();
    test_drop_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
